// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_pkg
//  Description : Shared constants for the load-cell A2D path.
//                - ADC channel numbers for the four sensed quantities.
//                - Top-level sequencer state encoding.
//                - SCLK divider preset and compare points, derived from the
//                  divider width.
//                - Round-robin index to channel mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package a2d_pkg;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CNV  = 2'b01,
        DEAD = 2'b10,
        READ = 2'b11
    } a2d_state_e;

    // Preset gives a short front porch: SCLK is high for the top quarter of
    // the divider range minus one count before the first fall
    // (5'b10111 at w = 5).
    function automatic int unsigned div_preset(input int unsigned w);
        return (1 << w) - (1 << (w - 2)) - 1;
    endfunction

    // One clock before SCLK rises (5'b01111 at w = 5).
    function automatic int unsigned div_sample(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    // One clock before SCLK falls (5'b11111 at w = 5).
    function automatic int unsigned div_shift(input int unsigned w);
        return (1 << w) - 1;
    endfunction

    function automatic logic [2:0] rr_channel(input logic [1:0] idx);
        case (idx)
            2'd0:    return CH_LFT;
            2'd1:    return CH_RGHT;
            2'd2:    return CH_STEER;
            default: return CH_BATT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_intf_if.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_intf_if
//  Description : Four-wire SPI bus between the A2D interface and the ADC.
//                - SS_n : slave select, active low
//                - SCLK : serial clock, idles high
//                - MOSI : data to the ADC
//                - MISO : data from the ADC
//                The master modport is the controller side and the slave
//                modport is the ADC side.
//  Revision    : 1.0  initial release
// ============================================================================
interface a2d_intf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface
`default_nettype wire

// File: rtl/spi_mnrch.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mnrch
//  Description : 16-bit SPI master (mode 3: SCLK idles high). A wrt pulse
//                starts one transaction and done pulses one clock when it
//                completes.
//  Ports       : clk, rst_n     - clock, asynchronous active-low reset
//                wrt, cmd[15:0] - start strobe and word to transmit
//                done           - one-clock completion pulse
//                rd_data[15:0]  - word received, valid from done onward
//                SS_n, SCLK, MOSI, MISO - SPI pins
//  Revision    : 1.0  initial release
// ============================================================================
module spi_mnrch
    import a2d_pkg::*;
#(
    parameter int CLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [CLK_DIV_W-1:0] C_PRESET = CLK_DIV_W'(div_preset(CLK_DIV_W));
    localparam logic [CLK_DIV_W-1:0] C_SAMPLE = CLK_DIV_W'(div_sample(CLK_DIV_W));
    localparam logic [CLK_DIV_W-1:0] C_SHIFT  = CLK_DIV_W'(div_shift(CLK_DIV_W));

    logic [CLK_DIV_W-1:0] r_div;
    logic [15:0]          r_shft;
    logic [4:0]           r_fall_cnt;
    logic                 r_miso;
    logic                 r_ss_n;
    logic                 r_done;

    logic w_fall;
    logic w_smpl;
    logic w_last;

    assign w_fall = ~r_ss_n && (r_div == C_SHIFT);
    assign w_smpl = ~r_ss_n && (r_div == C_SAMPLE);
    // The 17th fall point: sixteen bits have been sampled; it carries the
    // final shift and parks SCLK instead of actually falling.
    assign w_last = w_fall && (r_fall_cnt == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_n     <= 1'b1;
            r_div      <= C_PRESET;
            r_shft     <= '0;
            r_fall_cnt <= '0;
            r_miso     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (wrt && r_ss_n) begin
                r_ss_n     <= 1'b0;
                r_div      <= C_PRESET;
                r_shft     <= cmd;
                r_fall_cnt <= '0;
            end else if (!r_ss_n) begin
                // Reloading the preset parks SCLK high between transactions.
                r_div <= w_last ? C_PRESET : r_div + 1'b1;
                if (w_smpl) begin
                    r_miso <= MISO;
                end
                if (w_fall) begin
                    r_fall_cnt <= r_fall_cnt + 5'd1;
                    // The first fall only ends the front porch; MOSI bit 15
                    // must stay up for the first rising edge.
                    if (r_fall_cnt != 5'd0) begin
                        r_shft <= {r_shft[14:0], r_miso};
                    end
                end
                if (w_last) begin
                    r_ss_n <= 1'b1;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign SS_n    = r_ss_n;
    assign SCLK    = r_div[CLK_DIV_W-1];
    assign MOSI    = r_shft[15];
    assign done    = r_done;
    assign rd_data = r_shft;

endmodule
`default_nettype wire

// File: rtl/a2d_intf.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_intf
//  Description : Round-robin sampler for the 8-channel 12-bit ADC. Each nxt
//                pulse in IDLE runs one conversion as two SPI transactions:
//                a channel select, then a result readback. Channels are
//                visited in the order 0, 4, 5, 6.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                nxt          - start a conversion (ignored unless idle)
//                lft_ld       - channel 0 result
//                rght_ld      - channel 4 result
//                steer_pot    - channel 5 result
//                batt         - channel 6 result
//                spi          - SPI bus to the ADC (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int CLK_DIV_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           nxt,
    output logic [11:0]    lft_ld,
    output logic [11:0]    rght_ld,
    output logic [11:0]    steer_pot,
    output logic [11:0]    batt,
    a2d_intf_if.master     spi
);

    a2d_state_e  r_state;
    a2d_state_e  w_nxt_state;
    logic [1:0]  r_idx;
    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic [11:0] r_steer;
    logic [11:0] r_batt;

    logic        w_wrt;
    logic [15:0] w_cmd;
    logic        w_load;
    logic        w_done;
    logic [15:0] w_rd_data;
    // The ADC's top nibble carries no result bits and is dropped.
    logic [3:0]  w_unused_rd_hi;

    assign w_unused_rd_hi = w_rd_data[15:12];

    spi_mnrch #(
        .CLK_DIV_W (CLK_DIV_W)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (w_wrt),
        .cmd     (w_cmd),
        .done    (w_done),
        .rd_data (w_rd_data),
        .SS_n    (spi.SS_n),
        .SCLK    (spi.SCLK),
        .MOSI    (spi.MOSI),
        .MISO    (spi.MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_wrt       = 1'b0;
        w_cmd       = 16'h0000;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (nxt) begin
                    w_wrt       = 1'b1;
                    w_cmd       = {2'b00, rr_channel(r_idx), 11'h000};
                    w_nxt_state = CNV;
                end
            end
            CNV: begin
                if (w_done) begin
                    w_nxt_state = DEAD;
                end
            end
            DEAD: begin
                // The engine raised SS_n on done, so it is high for this
                // whole clock before the readback starts.
                w_wrt       = 1'b1;
                w_nxt_state = READ;
            end
            READ: begin
                if (w_done) begin
                    w_load      = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 2'd0;
            r_lft   <= 12'h000;
            r_rght  <= 12'h000;
            r_steer <= 12'h000;
            r_batt  <= 12'h000;
        end else if (w_load) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_lft   <= w_rd_data[11:0];
                2'd1:    r_rght  <= w_rd_data[11:0];
                2'd2:    r_steer <= w_rd_data[11:0];
                default: r_batt  <= w_rd_data[11:0];
            endcase
        end
    end

    assign lft_ld    = r_lft;
    assign rght_ld   = r_rght;
    assign steer_pot = r_steer;
    assign batt      = r_batt;

endmodule
`default_nettype wire
